uart_mem_arbiter_n: RTL and testbench

- Generalised data-memory arbiter for the pipelined MIPS32 core. It serves the CPU MEM stage and NUM_CH UART channels.
- Each RX channel owns a ring-buffer region in data memory. Received bytes are written into that ring during cycles the CPU does not use memory.
- CPU stores to memory-mapped TX addresses start UART transmissions, stalling the core while the target transmitter is busy.
- Sits between the EX_MEM outputs, the uart instances and the dataMem port muxes.

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/uart_mem_arbiter_n_rr_arbiter.sv | 60 ++++++
 rtl/uart_mem_arbiter_n.sv | 148 ++++++++++++++
 tb/tb_uart_mem_arbiter_n.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and decode constants for uart_mem_arbiter_n and its round-robin arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RX_WR, S_TX_WAIT} state_t;

  // TX/ACK windows are 8 addresses wide; the low bits select the channel.
  localparam int CH_FIELD_W = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_mem_arbiter_n_rr_arbiter.sv
// Request vector to one-hot grant. Round-robin by default; UART_ARB_FIXED_PRIO_EN selects
// fixed priority (lowest index wins) and drops the pointer.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int CW = idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              update,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     idx,
  output logic              valid
);

`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused;
  assign unused = ^{clk, rst, update};

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = CW'(i);
        valid = 1'b1;
      end
    end
    if (valid) grant = NUM_CH'(1) << idx;
  end
`else
  // ptr is the first channel searched; it moves just past each winner.
  logic [CW-1:0] ptr;
  int            c;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (int'(ptr) + k) % NUM_CH;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = CW'(c);
      end
    end
    if (valid) grant = NUM_CH'(1) << idx;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (update && valid) ptr <= CW'((int'(idx) + 1) % NUM_CH);
  end
`endif

endmodule

// File: rtl/uart_mem_arbiter_n.sv
// Data-memory arbiter between the CPU MEM stage and NUM_CH UART channels (RX rings, TX starts).
// Build option: UART_ARB_FIXED_PRIO_EN (fixed-priority RX arbitration instead of round-robin).
module uart_mem_arbiter_n
  import uart_arb_pkg::*;
#(
  parameter int                NUM_CH   = 2,
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RX_BASE  = 10'h300,
  parameter int                RX_DEPTH = 16,
  parameter logic [ADDR_W-1:0] TX_BASE  = 10'h3F0,
  parameter logic [ADDR_W-1:0] ACK_BASE = 10'h3F8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [NUM_CH-1:0] rx_ready,
  input  logic [NUM_CH-1:0] tx_busy,
  output logic [NUM_CH-1:0] rx_grant,
  output logic [NUM_CH-1:0] rx_clear,
  output logic [ADDR_W-1:0] rx_addr,
  output logic              rx_write,
  output logic              cpu_wren,
  output logic [NUM_CH-1:0] tx_enable,
  output logic              cpu_stall,
  output logic [NUM_CH-1:0] rx_full
);

  localparam int CW = idx_w(NUM_CH);
  localparam int PW = $clog2(RX_DEPTH);
  localparam int NW = PW + 1;

  state_t state, state_next;

  logic [PW-1:0]     wr_ptr [NUM_CH];
  logic [NW-1:0]     count  [NUM_CH];
  logic [CW-1:0]     tx_ch, gnt_ch, tx_sel, ack_sel, arb_idx;
  logic [ADDR_W-1:0] tx_off, ack_off, rx_addr_q;
  logic [NUM_CH-1:0] eligible, arb_grant, rx_grant_q, full, inc, dec;
  logic              tx_hit, ack_hit, cpu_active, arb_valid, grant_now, ack_now, rx_write_q;

  assign cpu_active = cpu_mem_read | cpu_mem_write;
  assign tx_off     = cpu_addr - TX_BASE;
  assign ack_off    = cpu_addr - ACK_BASE;
  assign tx_sel     = tx_off[CW-1:0];
  assign ack_sel    = ack_off[CW-1:0];
  assign tx_hit     = cpu_mem_write && (tx_off[ADDR_W-1:CH_FIELD_W] == '0)
                      && ({1'b0, tx_off[CH_FIELD_W-1:0]} < (CH_FIELD_W + 1)'(NUM_CH));
  assign ack_hit    = cpu_mem_write && (ack_off[ADDR_W-1:CH_FIELD_W] == '0)
                      && ({1'b0, ack_off[CH_FIELD_W-1:0]} < (CH_FIELD_W + 1)'(NUM_CH));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      full[i] = (count[i] == NW'(RX_DEPTH));
      inc[i]  = (state == S_RX_WR) && (gnt_ch == CW'(i));
      dec[i]  = ack_now && (ack_sel == CW'(i)) && (count[i] != '0);
    end
  end

  assign eligible  = rx_ready & ~full;
  assign grant_now = (state == S_IDLE) && !cpu_active && arb_valid;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (eligible),
    .update (grant_now),
    .grant  (arb_grant),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (tx_hit && tx_busy[tx_sel]) state_next = S_TX_WAIT;
        else if (grant_now)            state_next = S_RX_WR;
      end
      S_RX_WR:   state_next = S_IDLE;
      S_TX_WAIT: if (!tx_busy[tx_ch]) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // A CPU access that meets an RX write is stalled and replayed, so none of its side effects apply here.
  always_comb begin
    cpu_wren  = 1'b0;
    cpu_stall = 1'b0;
    tx_enable = '0;
    ack_now   = 1'b0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          cpu_wren = cpu_mem_write && !tx_hit && !ack_hit;
          ack_now  = ack_hit;
          if (tx_hit) begin
            if (tx_busy[tx_sel]) cpu_stall = 1'b1;
            else                 tx_enable = NUM_CH'(1) << tx_sel;
          end
        end
        S_RX_WR: cpu_stall = cpu_active;
        S_TX_WAIT: begin
          if (tx_busy[tx_ch]) cpu_stall = 1'b1;
          else                tx_enable = NUM_CH'(1) << tx_ch;
        end
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_write_q <= 1'b0;
      rx_grant_q <= '0;
      rx_addr_q  <= '0;
      tx_ch      <= '0;
      gnt_ch     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      state      <= state_next;
      rx_write_q <= grant_now;
      rx_grant_q <= grant_now ? arb_grant : '0;
      rx_addr_q  <= grant_now ? ADDR_W'(int'(RX_BASE) + int'(arb_idx) * RX_DEPTH
                                        + int'(wr_ptr[arb_idx])) : '0;
      if (state == S_IDLE && tx_hit) tx_ch <= tx_sel;
      if (grant_now) gnt_ch <= arb_idx;
      for (int i = 0; i < NUM_CH; i++) begin
        if (inc[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (inc[i] && !dec[i])      count[i] <= count[i] + NW'(1);
        else if (dec[i] && !inc[i]) count[i] <= count[i] - NW'(1);
      end
    end
  end

  // Reset forces every output low immediately, including an rx_clear already in flight.
  assign rx_write = rx_write_q && !rst;
  assign rx_grant = rst ? '0 : rx_grant_q;
  assign rx_clear = rst ? '0 : rx_grant_q;
  assign rx_addr  = rst ? '0 : rx_addr_q;
  assign rx_full  = rst ? '0 : full;

endmodule

// File: tb/tb_uart_mem_arbiter_n.sv
// Bench for uart_mem_arbiter_n: directed cases plus randomized traffic against a behavioural model.
module tb_uart_mem_arbiter_n;

  localparam int N    = 2;
  localparam int D    = 4;
  localparam int RXB  = 'h300;
  localparam int TXB  = 'h3F0;
  localparam int ACKB = 'h3F8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [9:0]   cpu_addr = '0;
  logic         cpu_mem_read = 1'b0, cpu_mem_write = 1'b0;
  logic [N-1:0] rx_pend = '0, tx_busy = '0;
  logic [N-1:0] rx_grant, rx_clear, tx_enable, rx_full;
  logic [9:0]   rx_addr;
  logic         rx_write, cpu_wren, cpu_stall;

  always #5 clk = ~clk;

  uart_mem_arbiter_n #(.NUM_CH(N), .ADDR_W(10), .RX_BASE(10'h300), .RX_DEPTH(D),
                       .TX_BASE(10'h3F0), .ACK_BASE(10'h3F8)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_mem_read(cpu_mem_read),
    .cpu_mem_write(cpu_mem_write), .rx_ready(rx_pend), .tx_busy(tx_busy),
    .rx_grant(rx_grant), .rx_clear(rx_clear), .rx_addr(rx_addr), .rx_write(rx_write),
    .cpu_wren(cpu_wren), .tx_enable(tx_enable), .cpu_stall(cpu_stall), .rx_full(rx_full)
  );

  int n_checks = 0, n_fail = 0;
  logic [9:0] exp_q[$];

  // Behavioural model: ring bookkeeping plus the one pending RX write or TX wait.
  int m_wp[N], m_cnt[N];
  bit m_wr_busy, m_tx_wait;
  int m_wr_ch, m_wr_addr, m_tx_ch, m_rr;
  bit last_stall;

  logic [N-1:0] obs_grant, obs_clear, obs_txen, obs_full;
  logic [9:0]   obs_addr;
  logic         obs_write, obs_wren, obs_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_wp[i]  = 0;
      m_cnt[i] = 0;
    end
    m_wr_busy = 0;
    m_tx_wait = 0;
    m_rr      = 0;
    exp_q.delete();
  endtask

  // One clock: check outputs at the negedge, advance the model, then apply uart-side clears.
  task automatic tick();
    logic [N-1:0] e_grant, e_txen, e_full;
    logic [9:0]   e_addr;
    logic         e_write, e_wren, e_stall, tx_hit, ack_hit;
    int a, tx_c, ack_c, pick, c;
    @(negedge clk);
    a       = int'(cpu_addr);
    tx_c    = a - TXB;
    ack_c   = a - ACKB;
    tx_hit  = cpu_mem_write && a >= TXB && a < TXB + N;
    ack_hit = cpu_mem_write && a >= ACKB && a < ACKB + N;
    e_grant = '0; e_txen = '0; e_full = '0; e_addr = '0;
    e_write = 0; e_wren = 0; e_stall = 0;
    if (!rst) begin
      for (int i = 0; i < N; i++) e_full[i] = (m_cnt[i] == D);
      if (m_wr_busy) begin
        e_write = 1; e_grant[m_wr_ch] = 1'b1; e_addr = 10'(m_wr_addr);
        e_stall = cpu_mem_read || cpu_mem_write;
      end else if (m_tx_wait) begin
        if (tx_busy[m_tx_ch]) e_stall = 1; else e_txen[m_tx_ch] = 1'b1;
      end else begin
        e_wren = cpu_mem_write && !tx_hit && !ack_hit;
        if (tx_hit) begin
          if (tx_busy[tx_c]) e_stall = 1; else e_txen[tx_c] = 1'b1;
        end
      end
    end
    obs_grant = rx_grant; obs_clear = rx_clear; obs_txen = tx_enable; obs_full = rx_full;
    obs_addr = rx_addr; obs_write = rx_write; obs_wren = cpu_wren; obs_stall = cpu_stall;
    check("rx_write", obs_write, e_write);
    check("rx_grant", obs_grant, e_grant);
    check("rx_clear", obs_clear, e_grant);
    check("rx_addr", obs_addr, e_addr);
    check("rx_full", obs_full, e_full);
    check("cpu_wren", obs_wren, e_wren);
    check("cpu_stall", obs_stall, e_stall);
    check("tx_enable", obs_txen, e_txen);
    if (obs_write) begin
      if (exp_q.size() == 0) check("sb_unexpected_write", 1, 0);
      else check("sb_addr", obs_addr, exp_q.pop_front());
    end
    if (rst) model_reset();
    else if (m_wr_busy) begin
      m_wp[m_wr_ch] = (m_wp[m_wr_ch] + 1) % D;
      m_cnt[m_wr_ch]++;
      m_wr_busy = 0;
    end else if (m_tx_wait) begin
      if (!tx_busy[m_tx_ch]) m_tx_wait = 0;
    end else begin
      if (ack_hit && m_cnt[ack_c] > 0) m_cnt[ack_c]--;
      if (tx_hit && tx_busy[tx_c]) begin
        m_tx_wait = 1; m_tx_ch = tx_c;
      end else if (!(cpu_mem_read || cpu_mem_write)) begin
        pick = -1;
        for (int k = 0; k < N; k++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
          c = k;
`else
          c = (m_rr + k) % N;
`endif
          if (pick < 0 && rx_pend[c] && m_cnt[c] < D) pick = c;
        end
        if (pick >= 0) begin
          m_rr = (pick + 1) % N;
          m_wr_busy = 1; m_wr_ch = pick;
          m_wr_addr = RXB + pick * D + m_wp[pick];
          exp_q.push_back(10'(m_wr_addr));
        end
      end
    end
    last_stall = e_stall;
    @(posedge clk);
    #1;
    rx_pend = rx_pend & ~e_grant;
  endtask

  task automatic do_reset();
    rx_pend = '0; tx_busy = '0; cpu_mem_read = 0; cpu_mem_write = 0; cpu_addr = '0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic cpu_idle();
    cpu_mem_read = 0; cpu_mem_write = 0; cpu_addr = '0;
  endtask

  initial begin
    logic [9:0] got_a[4];
    logic [9:0] want_a[4];
    int n, w;
    model_reset();
    last_stall = 0;
    rst = 1;
    tick();
    check("reset_outputs", {obs_write, obs_grant, obs_addr, obs_wren, obs_stall, obs_txen, obs_full}, 0);
    rst = 0;

    // Single ch0 bytes land at 0x300 then 0x301.
    rx_pend[0] = 1; tick(); tick();
    check("tp1_write", obs_write, 1);
    check("tp1_grant", obs_grant, 2'b01);
    check("tp1_clear", obs_clear, 2'b01);
    check("tp1_addr0", obs_addr, 10'h300);
    rx_pend[0] = 1; tick(); tick();
    check("tp1_addr1", obs_addr, 10'h301);

    // Both channels kept busy.
    do_reset();
`ifdef UART_ARB_FIXED_PRIO_EN
    want_a = '{10'h300, 10'h301, 10'h302, 10'h303};
`else
    want_a = '{10'h300, 10'h304, 10'h301, 10'h305};
`endif
    n = 0;
    for (int i = 0; i < 12 && n < 4; i++) begin
      rx_pend = 2'b11;
      tick();
      if (obs_write) begin got_a[n] = obs_addr; n++; end
    end
    check("tp2_count", n, 4);
    for (int i = 0; i < 4; i++) check("tp2_addr", got_a[i], want_a[i]);

    // Fill ch1, confirm no grant when full, ACK frees a slot, pointer wraps.
    do_reset();
    for (int i = 0; i < 4; i++) begin rx_pend[1] = 1; tick(); tick(); end
    rx_pend = '0; tick();
    check("tp3_full", obs_full, 2'b10);
    rx_pend[1] = 1; w = 0;
    for (int i = 0; i < 3; i++) begin tick(); w += int'(obs_write); end
    check("tp3_no_grant", w, 0);
    cpu_mem_write = 1; cpu_addr = 10'h3F9; tick();
    check("tp3_ack_wren", obs_wren, 0);
    cpu_idle(); tick();
    check("tp3_not_full", obs_full, 2'b00);
    tick();
    check("tp3_wrap_addr", {obs_write, obs_addr}, {1'b1, 10'h304});

    // TX store while busy stalls, then fires as the stall releases.
    do_reset();
    tx_busy = 2'b01; cpu_mem_write = 1; cpu_addr = 10'h3F0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("tp4_stall", {obs_stall, obs_wren, obs_txen}, {1'b1, 1'b0, 2'b00});
    end
    tx_busy = 2'b00; tick();
    check("tp4_release", {obs_stall, obs_wren, obs_txen}, {1'b0, 1'b0, 2'b01});
    cpu_idle(); tick();
    check("tp4_pulse_end", obs_txen, 2'b00);

    // CPU load blocks grants; normal store is forwarded.
    do_reset();
    rx_pend[0] = 1; cpu_mem_read = 1;
    for (int i = 0; i < 3; i++) begin tick(); check("tp5_blocked", obs_write, 0); end
    cpu_idle(); tick();
    check("tp5_decide", obs_write, 0);
    tick();
    check("tp5_grant", {obs_write, obs_addr}, {1'b1, 10'h300});
    cpu_mem_write = 1; cpu_addr = 10'h100; tick();
    check("tp5_wren", obs_wren, 1);
    cpu_idle();

    // Reset during the RX write cycle drops it.
    do_reset();
    rx_pend[0] = 1; tick();
    rst = 1; tick();
    check("tp6_in_reset", {obs_write, obs_clear, obs_addr}, 0);
    rst = 0; tick();
    check("tp6_after", {obs_write, obs_grant, obs_addr}, 0);
    tick();
    check("tp6_addr", {obs_write, obs_addr}, {1'b1, 10'h300});

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (!last_stall) begin
        cpu_idle();
        cpu_addr = 10'($urandom_range(0, 1023));
        case ($urandom_range(0, 9))
          0, 1: cpu_mem_read = 1;
          2: cpu_mem_write = 1;
          3: begin cpu_mem_write = 1; cpu_addr = 10'(TXB + $urandom_range(0, 3)); end
          4: begin cpu_mem_write = 1; cpu_addr = 10'(ACKB + $urandom_range(0, 3)); end
          default: ;
        endcase
      end
      for (int ch = 0; ch < N; ch++) begin
        if (!rx_pend[ch] && $urandom_range(0, 3) == 0) rx_pend[ch] = 1;
        tx_busy[ch] = ($urandom_range(0, 2) == 0);
      end
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 0; rx_pend = '0; tx_busy = '0; cpu_idle();
    for (int i = 0; i < 6; i++) tick();
    check("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
